// File: rtl/prince_round_ctrl_pkg.sv
// Shared definitions for the PRINCE round controller: operation selects,
// FSM state encoding, round-constant table and the alpha reflection constant.
package prince_round_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_HOLD  = 3'd0,
      OP_LOAD  = 3'd1,
      OP_FWD   = 3'd2,
      OP_MID   = 3'd3,
      OP_INV   = 3'd4,
      OP_FINAL = 3'd5
   } op_sel_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FWD   = 3'd1,
      ST_MID   = 3'd2,
      ST_INV   = 3'd3,
      ST_FINAL = 3'd4,
      ST_DONE  = 3'd5
   } ctrl_state_e;

   localparam logic [63:0] ALPHA_DEFAULT = 64'hc0ac29b7c97c50dd;

   localparam logic [63:0] RC_00 = 64'h0000000000000000;
   localparam logic [63:0] RC_01 = 64'h13198a2e03707344;
   localparam logic [63:0] RC_02 = 64'ha4093822299f31d0;
   localparam logic [63:0] RC_03 = 64'h082efa98ec4e6c89;
   localparam logic [63:0] RC_04 = 64'h452821e638d01377;
   localparam logic [63:0] RC_05 = 64'hbe5466cf34e90c6c;
   localparam logic [63:0] RC_06 = 64'h7ef84f78fd955cb1;
   localparam logic [63:0] RC_07 = 64'h85840851f1ac43aa;
   localparam logic [63:0] RC_08 = 64'hc882d32f25323c54;
   localparam logic [63:0] RC_09 = 64'h64a51195e0e3610d;
   localparam logic [63:0] RC_10 = 64'hd3b5a399ca0c2399;
   localparam logic [63:0] RC_11 = 64'hc0ac29b7c97c50dd;

   // Unused indices 12..15 read as zero so a stray index never injects a constant.
   function automatic logic [63:0] rc_lookup(input logic [3:0] idx);
      logic [63:0] val;
      case (idx)
         4'd0:    val = RC_00;
         4'd1:    val = RC_01;
         4'd2:    val = RC_02;
         4'd3:    val = RC_03;
         4'd4:    val = RC_04;
         4'd5:    val = RC_05;
         4'd6:    val = RC_06;
         4'd7:    val = RC_07;
         4'd8:    val = RC_08;
         4'd9:    val = RC_09;
         4'd10:   val = RC_10;
         4'd11:   val = RC_11;
         default: val = 64'h0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/prince_round_ctrl_if.sv
// Handshake and datapath-control bundle between the PRINCE round controller
// (slave) and the block source / round datapath / result consumer (master).
interface prince_round_ctrl_if;
   import prince_round_ctrl_pkg::*;

   logic        in_valid;
   logic        in_ready;
   logic        decrypt_in;
   logic        out_valid;
   logic        out_ready;
   logic        state_en;
   op_sel_e     op_sel;
   logic [63:0] rc;
   logic [3:0]  rc_idx;
   logic        dec_mode;
   logic [63:0] alpha;
   logic        busy;

   modport slave (
      input  in_valid,
      input  decrypt_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output state_en,
      output op_sel,
      output rc,
      output rc_idx,
      output dec_mode,
      output alpha,
      output busy
   );

   modport master (
      output in_valid,
      output decrypt_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  state_en,
      input  op_sel,
      input  rc,
      input  rc_idx,
      input  dec_mode,
      input  alpha,
      input  busy
   );

endinterface

// File: rtl/prince_round_ctrl_rc_rom.sv
// Combinational PRINCE round-constant ROM, indexed 0..11.
module prince_rc_rom
   import prince_round_ctrl_pkg::*;
(
   input  logic [3:0]  idx,
   output logic [63:0] rc
);

   always_comb begin
      rc = rc_lookup(idx);
   end

endmodule

// File: rtl/prince_round_ctrl.sv
// Sequencer for the iterative PRINCE datapath: load/whiten, forward rounds,
// middle layer, inverse rounds, final whitening, then hold the result.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | ready for a block; LOAD op, state_en follows in_valid
//   FWD      | HALF_ROUNDS forward rounds, rc_idx 1..HALF_ROUNDS
//   MID      | one middle-layer cycle, rc_idx 0
//   INV      | HALF_ROUNDS inverse rounds, rc_idx 11-HALF_ROUNDS..10
//   FINAL    | final whitening with RC11
//   DONE     | result held in the datapath, out_valid until out_ready
module prince_round_ctrl
   import prince_round_ctrl_pkg::*;
#(
   parameter int          HALF_ROUNDS = 5,
   parameter logic [63:0] ALPHA       = ALPHA_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   prince_round_ctrl_if.slave    bus
);

   localparam logic [3:0] HR4     = 4'(HALF_ROUNDS);
   localparam logic [2:0] HR_LAST = 3'(HALF_ROUNDS - 1);

   ctrl_state_e state, state_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic        dec_mode, dec_mode_nxt;

   logic        in_ready;
   logic        out_valid;
   logic        state_en;
   logic        busy;
   op_sel_e     op_sel;
   logic [3:0]  rc_idx;
   logic [63:0] rc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= 3'd0;
         dec_mode <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         dec_mode <= dec_mode_nxt;
      end
   end

   // cnt is a down-counter: it starts at HALF_ROUNDS-1 for each round phase
   // and the phase ends on terminal count 0; rc_idx is derived from it.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      dec_mode_nxt = dec_mode;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      state_en     = 1'b0;
      busy         = 1'b1;
      op_sel       = OP_HOLD;
      rc_idx       = 4'd0;

      case (state)
         ST_IDLE: begin
            busy     = 1'b0;
            in_ready = 1'b1;
            op_sel   = OP_LOAD;
            state_en = bus.in_valid;
            if (bus.in_valid) begin
               state_nxt    = ST_FWD;
               cnt_nxt      = HR_LAST;
               dec_mode_nxt = bus.decrypt_in;
            end
         end

         ST_FWD: begin
            op_sel   = OP_FWD;
            state_en = 1'b1;
            rc_idx   = HR4 - {1'b0, cnt};
            if (cnt == 3'd0) begin
               state_nxt = ST_MID;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end

         ST_MID: begin
            op_sel    = OP_MID;
            state_en  = 1'b1;
            state_nxt = ST_INV;
            cnt_nxt   = HR_LAST;
         end

         ST_INV: begin
            op_sel   = OP_INV;
            state_en = 1'b1;
            rc_idx   = 4'd10 - {1'b0, cnt};
            if (cnt == 3'd0) begin
               state_nxt = ST_FINAL;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end

         ST_FINAL: begin
            op_sel    = OP_FINAL;
            state_en  = 1'b1;
            rc_idx    = 4'd11;
            state_nxt = ST_DONE;
         end

         ST_DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            busy      = 1'b0;
            state_nxt = ST_IDLE;
            cnt_nxt   = 3'd0;
         end
      endcase
   end

   prince_rc_rom u_rc_rom (
      .idx (rc_idx),
      .rc  (rc)
   );

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.state_en  = state_en;
   assign bus.busy      = busy;
   assign bus.op_sel    = op_sel;
   assign bus.rc_idx    = rc_idx;
   assign bus.rc        = rc;
   assign bus.dec_mode  = dec_mode;
   assign bus.alpha     = ALPHA;

endmodule

// File: tb/tb_prince_round_ctrl.sv
// Directed bench for prince_round_ctrl: full-round instance plus a
// HALF_ROUNDS=2 reduced instance.
module tb_prince_round_ctrl;

   logic clk;
   logic rst_n;

   prince_round_ctrl_if bus();
   prince_round_ctrl_if bus2();

   prince_round_ctrl #(.HALF_ROUNDS(5)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   prince_round_ctrl #(.HALF_ROUNDS(2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [63:0] rc_exp [16];

   typedef struct {
      logic       iv;
      logic       ordy;
      logic       e_ir;
      logic       e_se;
      logic [2:0] e_op;
      logic [3:0] e_idx;
      logic       e_ov;
      logic       e_busy;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(input logic iv, input logic ordy, input logic ir,
                               input logic se, input logic [2:0] op,
                               input logic [3:0] idx, input logic ov,
                               input logic bz);
      vec_t v;
      v.iv = iv; v.ordy = ordy; v.e_ir = ir; v.e_se = se;
      v.e_op = op; v.e_idx = idx; v.e_ov = ov; v.e_busy = bz;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Full 15-cycle transaction from the accept cycle to the IDLE cycle after
   // the output handshake; noise toggles in_valid/decrypt_in while busy.
   task automatic run_table(input logic dec, input logic noise, input logic prev_dm);
      for (int i = 0; i < 15; i++) begin
         next_cycle();
         bus.in_valid   = tbl[i].iv;
         bus.decrypt_in = (i == 0) ? dec : 1'b0;
         bus.out_ready  = tbl[i].ordy;
         if (noise && i >= 1 && i <= 12) begin
            bus.in_valid   = i[0];
            bus.decrypt_in = ~dec;
         end
         @(negedge clk);
         chk($sformatf("tbl%0d_in_ready", i),  bus.in_ready,  tbl[i].e_ir);
         chk($sformatf("tbl%0d_state_en", i),  bus.state_en,  tbl[i].e_se);
         chk($sformatf("tbl%0d_op_sel", i),    bus.op_sel,    tbl[i].e_op);
         chk($sformatf("tbl%0d_rc_idx", i),    bus.rc_idx,    tbl[i].e_idx);
         chk($sformatf("tbl%0d_rc", i),        bus.rc,        rc_exp[tbl[i].e_idx]);
         chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].e_ov);
         chk($sformatf("tbl%0d_busy", i),      bus.busy,      tbl[i].e_busy);
         chk($sformatf("tbl%0d_dec_mode", i),  bus.dec_mode,  (i == 0) ? prev_dm : dec);
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic accept(input logic dec);
      next_cycle();
      bus.in_valid   = 1'b1;
      bus.decrypt_in = dec;
      @(negedge clk);
      chk("acc_in_ready", bus.in_ready, 1'b1);
      chk("acc_state_en", bus.state_en, 1'b1);
   endtask

   task automatic wait_valid(input int budget, output int lat);
      lat = 0;
      do begin
         next_cycle();
         bus.in_valid   = 1'b0;
         bus.decrypt_in = 1'b0;
         lat++;
         @(negedge clk);
      end while (!bus.out_valid && lat < budget);
      if (!bus.out_valid) begin
         errors++;
         $display("FAIL wait_valid: out_valid not seen within %0d cycles", budget);
      end
   endtask

   task automatic drain();
      next_cycle();
      bus.out_ready = 1'b1;
      @(negedge clk);
      next_cycle();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int seen;
      logic [2:0] exp_op2  [8];
      logic [3:0] exp_idx2 [8];

      rc_exp[0]  = 64'h0;
      rc_exp[1]  = 64'h13198a2e03707344;
      rc_exp[2]  = 64'ha4093822299f31d0;
      rc_exp[3]  = 64'h082efa98ec4e6c89;
      rc_exp[4]  = 64'h452821e638d01377;
      rc_exp[5]  = 64'hbe5466cf34e90c6c;
      rc_exp[6]  = 64'h7ef84f78fd955cb1;
      rc_exp[7]  = 64'h85840851f1ac43aa;
      rc_exp[8]  = 64'hc882d32f25323c54;
      rc_exp[9]  = 64'h64a51195e0e3610d;
      rc_exp[10] = 64'hd3b5a399ca0c2399;
      rc_exp[11] = 64'hc0ac29b7c97c50dd;
      for (int i = 12; i < 16; i++) rc_exp[i] = 64'h0;

      //            iv ordy ir se op idx ov busy
      tbl[0]  = mk(1, 0,   1, 1, 1, 0,  0, 0);
      tbl[1]  = mk(0, 0,   0, 1, 2, 1,  0, 1);
      tbl[2]  = mk(0, 0,   0, 1, 2, 2,  0, 1);
      tbl[3]  = mk(0, 0,   0, 1, 2, 3,  0, 1);
      tbl[4]  = mk(0, 0,   0, 1, 2, 4,  0, 1);
      tbl[5]  = mk(0, 0,   0, 1, 2, 5,  0, 1);
      tbl[6]  = mk(0, 0,   0, 1, 3, 0,  0, 1);
      tbl[7]  = mk(0, 0,   0, 1, 4, 6,  0, 1);
      tbl[8]  = mk(0, 0,   0, 1, 4, 7,  0, 1);
      tbl[9]  = mk(0, 0,   0, 1, 4, 8,  0, 1);
      tbl[10] = mk(0, 0,   0, 1, 4, 9,  0, 1);
      tbl[11] = mk(0, 0,   0, 1, 4, 10, 0, 1);
      tbl[12] = mk(0, 0,   0, 1, 5, 11, 0, 1);
      tbl[13] = mk(0, 1,   0, 0, 0, 0,  1, 1);
      tbl[14] = mk(0, 0,   1, 0, 1, 0,  0, 0);

      exp_op2  = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
      exp_idx2 = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd9, 4'd10, 4'd11, 4'd0};

      rst_n           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.decrypt_in  = 1'b0;
      bus.out_ready   = 1'b0;
      bus2.in_valid   = 1'b0;
      bus2.decrypt_in = 1'b0;
      bus2.out_ready  = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_in_ready",  bus.in_ready,  1'b1);
      chk("rst_state_en",  bus.state_en,  1'b0);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_busy",      bus.busy,      1'b0);
      chk("rst_op_sel",    bus.op_sel,    3'd1);
      chk("rst_rc_idx",    bus.rc_idx,    4'd0);
      chk("rst_rc",        bus.rc,        64'h0);
      chk("rst_dec_mode",  bus.dec_mode,  1'b0);
      chk("alpha",         bus.alpha,     64'hc0ac29b7c97c50dd);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // encrypt, then decrypt with in_valid/decrypt_in noise while busy
      run_table(1'b0, 1'b0, 1'b0);
      run_table(1'b1, 1'b1, 1'b0);

      // backpressure: out_ready held low for 7 cycles
      accept(1'b0);
      wait_valid(40, lat);
      chk("bp_latency", lat, 13);
      chk("bp_dec_mode", bus.dec_mode, 1'b0);
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         bus.in_valid = 1'b1;
         @(negedge clk);
         chk($sformatf("bp%0d_out_valid", i), bus.out_valid, 1'b1);
         chk($sformatf("bp%0d_op_sel", i),    bus.op_sel,    3'd0);
         chk($sformatf("bp%0d_state_en", i),  bus.state_en,  1'b0);
         chk($sformatf("bp%0d_in_ready", i),  bus.in_ready,  1'b0);
      end
      next_cycle();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_in_ready", bus.in_ready, 1'b0);
      next_cycle();
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("bp_after_in_ready",  bus.in_ready,  1'b1);
      chk("bp_after_out_valid", bus.out_valid, 1'b0);

      // asynchronous reset in the middle of the inverse rounds (T+7)
      accept(1'b1);
      for (int j = 1; j <= 7; j++) begin
         next_cycle();
         bus.in_valid = 1'b0;
         if (j < 7) @(negedge clk);
      end
      chk("mr_pre_op_sel", bus.op_sel, 3'd4);
      chk("mr_pre_dec_mode", bus.dec_mode, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mr_out_valid", bus.out_valid, 1'b0);
      chk("mr_busy",      bus.busy,      1'b0);
      chk("mr_dec_mode",  bus.dec_mode,  1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mr_rel_in_ready", bus.in_ready, 1'b1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         @(negedge clk);
         if (bus.out_valid || bus.busy) seen++;
      end
      chk("mr_no_activity", seen, 0);
      accept(1'b0);
      wait_valid(40, lat);
      chk("mr_new_latency", lat, 13);
      drain();

      // reduced-round instance
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         bus2.in_valid = (k == 0);
         @(negedge clk);
         chk($sformatf("hr2_%0d_op_sel", k),    bus2.op_sel,    exp_op2[k]);
         chk($sformatf("hr2_%0d_rc_idx", k),    bus2.rc_idx,    exp_idx2[k]);
         chk($sformatf("hr2_%0d_rc", k),        bus2.rc,        rc_exp[exp_idx2[k]]);
         chk($sformatf("hr2_%0d_out_valid", k), bus2.out_valid, (k == 7));
         chk($sformatf("hr2_%0d_busy", k),      bus2.busy,      (k != 0));
      end
      next_cycle();
      bus2.out_ready = 1'b1;
      @(negedge clk);
      next_cycle();
      bus2.out_ready = 1'b0;
      @(negedge clk);
      chk("hr2_after_in_ready", bus2.in_ready, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
